// File: rtl/fir_capture_buf_if.sv
// fir_capture_buf_if: capture stream tap plus request/valid readback port
interface fir_capture_buf_if #(
  parameter int OUT_SIZE = 16,
  parameter int CW = 9
);
  logic                fir_en;
  logic [OUT_SIZE-1:0] out_wave;
  logic                arm;
  logic                rd_req;
  logic                rd_valid;
  logic [OUT_SIZE-1:0] rd_data;
  logic [CW-1:0]       count;
  logic                busy;
  logic                done;
  logic                overflow;
  modport master (
    output fir_en, out_wave, arm, rd_req,
    input  rd_valid, rd_data, count, busy, done, overflow
  );
  modport slave (
    input  fir_en, out_wave, arm, rd_req,
    output rd_valid, rd_data, count, busy, done, overflow
  );
endinterface

// File: rtl/fir_capture_buf.sv
// fir_capture_buf: records the FIR output stream into a buffer and plays it back on request
module fir_capture_buf #(
  parameter int OUT_SIZE = 16,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst_n,
  fir_capture_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic [OUT_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr, count;
  logic [OUT_SIZE-1:0] rd_data;
  logic rd_valid, busy, done, overflow;
  logic clr, wr_en, rd_en;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.count    = count;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow;
  // arm restarts capture except mid-capture; the full write itself moves the FSM to DONE
  always_comb begin
    clr = bus.arm && state != CAPTURE;
    wr_en = state == CAPTURE && bus.fir_en;
    rd_en = state == DONE && bus.rd_req && !bus.arm && rd_ptr < count;
    state_nx = clr ? CAPTURE
             : (state == CAPTURE && ((wr_en && count == LAST) || (!bus.fir_en && count != '0))) ? DONE
             : state;
  end
  // state, pointers, status flags and registered readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= state_nx == CAPTURE;
      done     <= state_nx == DONE;
      wr_ptr   <= clr ? '0 : wr_en ? wr_ptr + AW'(1) : wr_ptr;
      count    <= clr ? '0 : wr_en ? count + CW'(1) : count;
      rd_ptr   <= clr ? '0 : rd_en ? rd_ptr + CW'(1) : rd_ptr;
      rd_valid <= rd_en;
      overflow <= clr ? 1'b0 : (state == DONE && bus.fir_en) ? 1'b1 : overflow;
      if (rd_en) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end
  // sample storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.out_wave;
  end
endmodule

// File: tb/tb_fir_capture_buf.sv
// tb_fir_capture_buf: directed checks of capture, full/overflow, readback and reset
module tb_fir_capture_buf;
  localparam int OUT_SIZE = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  fir_capture_buf_if #(.OUT_SIZE(OUT_SIZE), .CW(CW)) bus ();
  fir_capture_buf #(.OUT_SIZE(OUT_SIZE), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic read_one(input string tag, input logic [15:0] exp);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask
  task automatic arm_pulse();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask
  initial begin
    bus.fir_en = 1'b0;
    bus.out_wave = '0;
    bus.arm = 1'b0;
    bus.rd_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_release_busy", 32'(bus.busy), 32'd0);
    check("rst_release_done", 32'(bus.done), 32'd0);
    arm_pulse();
    check("armed_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("async_rst_ovf", 32'(bus.overflow), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("idle_rdreq_ignored", 32'(bus.rd_valid), 32'd0);
    arm_pulse();
    for (int i = 1; i <= 5; i++) begin
      bus.fir_en = 1'b1;
      bus.out_wave = 16'(i);
      step();
    end
    bus.fir_en = 1'b0;
    check("t2_count_capture", 32'(bus.count), 32'd5);
    check("t2_busy", 32'(bus.busy), 32'd1);
    step();
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_busy_low", 32'(bus.busy), 32'd0);
    check("t2_count", 32'(bus.count), 32'd5);
    check("t2_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 5; i++) read_one("t2_rd", 16'(i));
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t2_rd6_valid", 32'(bus.rd_valid), 32'd0);
    check("t2_rd6_hold", 32'(bus.rd_data), 32'h5);
    arm_pulse();
    for (int i = 0; i < 12; i++) begin
      bus.fir_en = 1'b1;
      bus.out_wave = 16'(16'h10 + i);
      step();
      if (i == 6) check("t3_not_done_yet", 32'(bus.done), 32'd0);
      if (i == 7) begin
        check("t3_done_at_full", 32'(bus.done), 32'd1);
        check("t3_count_full", 32'(bus.count), 32'd8);
        check("t3_ovf_before", 32'(bus.overflow), 32'd0);
      end
    end
    bus.fir_en = 1'b0;
    step();
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    check("t3_count", 32'(bus.count), 32'd8);
    check("t3_done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 8; i++) read_one("t3_rd", 16'(16'h10 + i));
    arm_pulse();
    check("t4_ovf_cleared", 32'(bus.overflow), 32'd0);
    check("t4_count_cleared", 32'(bus.count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.fir_en = 1'b1;
      bus.out_wave = 16'(16'h20 + i);
      step();
    end
    bus.arm = 1'b1;
    bus.out_wave = 16'h23;
    step();
    bus.arm = 1'b0;
    bus.fir_en = 1'b0;
    check("t4_arm_ignored_count", 32'(bus.count), 32'd4);
    check("t4_arm_ignored_busy", 32'(bus.busy), 32'd1);
    step();
    check("t4_done", 32'(bus.done), 32'd1);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_b2b_valid", 32'(bus.rd_valid), 32'd1);
      check("t5_b2b_data", 32'(bus.rd_data), 32'(16'h20 + i));
    end
    bus.rd_req = 1'b0;
    step();
    check("t5_valid_low", 32'(bus.rd_valid), 32'd0);
    arm_pulse();
    for (int i = 0; i < 2; i++) begin
      bus.fir_en = 1'b1;
      bus.out_wave = 16'(16'h40 + i);
      step();
    end
    bus.fir_en = 1'b0;
    step();
    check("t4b_done", 32'(bus.done), 32'd1);
    bus.arm = 1'b1;
    bus.rd_req = 1'b1;
    step();
    bus.arm = 1'b0;
    bus.rd_req = 1'b0;
    check("t4_arm_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t4_arm_rd_count", 32'(bus.count), 32'd0);
    check("t4_arm_rd_busy", 32'(bus.busy), 32'd1);
    step();
    check("t4_wait_first_busy", 32'(bus.busy), 32'd1);
    bus.fir_en = 1'b1;
    bus.out_wave = 16'h77;
    step();
    bus.fir_en = 1'b0;
    step();
    check("t4_single_done", 32'(bus.done), 32'd1);
    check("t4_single_count", 32'(bus.count), 32'd1);
    bus.arm = 1'b1;
    bus.fir_en = 1'b1;
    bus.out_wave = 16'hFF;
    step();
    bus.arm = 1'b0;
    check("t6_arm_sample_dropped", 32'(bus.count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.fir_en = 1'b1;
      bus.out_wave = 16'(16'h30 + i);
      step();
    end
    bus.fir_en = 1'b0;
    step();
    check("t6_count", 32'(bus.count), 32'd5);
    read_one("t6_rd", 16'h30);
    read_one("t6_rd", 16'h31);
    bus.rd_req = 1'b1;
    step();
    check("t6_third_valid", 32'(bus.rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    check("t6_rst_data", 32'(bus.rd_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t6_idle_valid", 32'(bus.rd_valid), 32'd0);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_done", 32'(bus.done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
